// File: rtl/regwr_arbiter.sv
// ============================================================================
//  Module   : regwr_arbiter
//  Purpose  : Shares one register-file write port between a single-result
//             requester (A) and a dual-result long-multiply requester (B).
//             Optional macro REGWR_RR_EN selects round-robin arbitration.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regwr_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [3:0]  a_addr,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [3:0]  b_addr_lo,
    input  logic [3:0]  b_addr_hi,
    input  logic [31:0] b_data_lo,
    input  logic [31:0] b_data_hi,
    output logic        we,
    output logic [3:0]  wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        pc_drop
);

    localparam logic [3:0] C_PC_ADDR = 4'hF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HI   = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_hi_sent;
    logic        w_hi_sent_nxt;
    logic [3:0]  r_hi_addr;
    logic [31:0] r_hi_data;
    logic        r_we;
    logic        r_pc_drop;
    logic [3:0]  r_wa;
    logic [31:0] r_wd;
    logic        w_grant_a;
    logic        w_a_acc;
    logic        w_b_acc;
    logic        w_issue;
    logic [3:0]  w_issue_addr;
    logic [31:0] w_issue_data;

`ifdef REGWR_RR_EN
    logic r_last_b;

    // On contention the requester that did not win last time is served.
    always_comb w_grant_a = a_valid && (!b_valid || r_last_b);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_b <= 1'b1;
        end else if (w_a_acc) begin
            r_last_b <= 1'b0;
        end else if (w_b_acc) begin
            r_last_b <= 1'b1;
        end
    end
`else
    always_comb w_grant_a = a_valid;
`endif

    // Ready depends only on state and request inputs, never on the write port.
    assign a_ready = !reset && (r_state == IDLE) && w_grant_a;
    assign b_ready = !reset && (r_state == IDLE) && b_valid && !w_grant_a;
    assign w_a_acc = a_valid && a_ready;
    assign w_b_acc = b_valid && b_ready;

    // HI spans the lo-write cycle and the hi-write cycle; r_hi_sent splits them.
    always_comb begin
        w_state_nxt   = r_state;
        w_hi_sent_nxt = r_hi_sent;
        w_issue       = 1'b0;
        w_issue_addr  = r_wa;
        w_issue_data  = r_wd;
        case (r_state)
            IDLE: begin
                if (w_a_acc) begin
                    w_issue      = 1'b1;
                    w_issue_addr = a_addr;
                    w_issue_data = a_data;
                end else if (w_b_acc) begin
                    w_issue       = 1'b1;
                    w_issue_addr  = b_addr_lo;
                    w_issue_data  = b_data_lo;
                    w_state_nxt   = HI;
                    w_hi_sent_nxt = 1'b0;
                end
            end
            HI: begin
                if (!r_hi_sent) begin
                    w_issue       = 1'b1;
                    w_issue_addr  = r_hi_addr;
                    w_issue_data  = r_hi_data;
                    w_hi_sent_nxt = 1'b1;
                end else begin
                    w_state_nxt   = IDLE;
                    w_hi_sent_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_hi_sent_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_hi_sent <= 1'b0;
            r_hi_addr <= 4'h0;
            r_hi_data <= 32'h0;
            r_we      <= 1'b0;
            r_pc_drop <= 1'b0;
            r_wa      <= 4'h0;
            r_wd      <= 32'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_hi_sent <= w_hi_sent_nxt;
            if (w_b_acc) begin
                r_hi_addr <= b_addr_hi;
                r_hi_data <= b_data_hi;
            end
            // Writes to the PC register are suppressed but still visible on wa/wd.
            r_we      <= w_issue && (w_issue_addr != C_PC_ADDR);
            r_pc_drop <= w_issue && (w_issue_addr == C_PC_ADDR);
            r_wa      <= w_issue_addr;
            r_wd      <= w_issue_data;
        end
    end

    assign we      = r_we;
    assign wa      = r_wa;
    assign wd      = r_wd;
    assign pc_drop = r_pc_drop;
    assign busy    = (r_state == HI);

endmodule

`default_nettype wire

// File: tb/tb_regwr_arbiter.sv
// ============================================================================
//  Module   : tb_regwr_arbiter
//  Purpose  : Self-checking bench for regwr_arbiter against a write-schedule
//             model (directed cases followed by random traffic).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regwr_arbiter;

    logic        clk;
    logic        reset;
    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [3:0]  b_addr_lo;
    logic [3:0]  b_addr_hi;
    logic [31:0] b_data_lo;
    logic [31:0] b_data_hi;
    logic        we;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic        busy;
    logic        pc_drop;

    regwr_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_addr_lo (b_addr_lo),
        .b_addr_hi (b_addr_hi),
        .b_data_lo (b_data_lo),
        .b_data_hi (b_data_hi),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .busy      (busy),
        .pc_drop   (pc_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    // Reference model: a schedule of writes still owed to the register file.
    wr_t         m_sched[$];
    int          m_busy_cnt;
    bit          m_last_b;
    logic        m_we;
    logic        m_pc;
    logic [3:0]  m_wa;
    logic [31:0] m_wd;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_sched.delete();
        m_busy_cnt = 0;
        m_last_b   = 1'b1;
        m_we       = 1'b0;
        m_pc       = 1'b0;
        m_wa       = 4'h0;
        m_wd       = 32'h0;
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic step(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [3:0] bal, input logic [3:0] bah,
                        input logic [31:0] bdl, input logic [31:0] bdh);
        bit  grant_a;
        bit  exp_ar;
        bit  exp_br;
        bit  has;
        wr_t cur;
        a_valid = av;  a_addr = aa;  a_data = ad;
        b_valid = bv;  b_addr_lo = bal;  b_addr_hi = bah;
        b_data_lo = bdl;  b_data_hi = bdh;
        #1;
`ifdef REGWR_RR_EN
        grant_a = av && (!bv || m_last_b);
`else
        grant_a = av;
`endif
        exp_ar = (m_busy_cnt == 0) && av && grant_a;
        exp_br = (m_busy_cnt == 0) && bv && !grant_a;
        check("a_ready", {31'b0, a_ready}, {31'b0, exp_ar});
        check("b_ready", {31'b0, b_ready}, {31'b0, exp_br});
        @(posedge clk);
        has = 1'b0;
        if (m_sched.size() > 0) begin
            cur = m_sched.pop_front();
            has = 1'b1;
        end else if (exp_ar) begin
            cur = '{addr: aa, data: ad};
            has = 1'b1;
            m_last_b = 1'b0;
        end else if (exp_br) begin
            cur = '{addr: bal, data: bdl};
            m_sched.push_back('{addr: bah, data: bdh});
            has = 1'b1;
            m_last_b = 1'b1;
        end
        if (exp_br)              m_busy_cnt = 2;
        else if (m_busy_cnt > 0) m_busy_cnt--;
        if (has) begin
            m_wa = cur.addr;
            m_wd = cur.data;
            m_we = (cur.addr != 4'hF);
            m_pc = (cur.addr == 4'hF);
        end else begin
            m_we = 1'b0;
            m_pc = 1'b0;
        end
        #1;
        check("we",      {31'b0, we},      {31'b0, m_we});
        check("wa",      {28'b0, wa},      {28'b0, m_wa});
        check("wd",      wd,               m_wd);
        check("pc_drop", {31'b0, pc_drop}, {31'b0, m_pc});
        check("busy",    {31'b0, busy},    {31'b0, m_busy_cnt > 0});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"},      {31'b0, we},      32'h0);
        check({tag, "_wa"},      {28'b0, wa},      32'h0);
        check({tag, "_wd"},      wd,               32'h0);
        check({tag, "_pc_drop"}, {31'b0, pc_drop}, 32'h0);
        check({tag, "_busy"},    {31'b0, busy},    32'h0);
        check({tag, "_a_ready"}, {31'b0, a_ready}, 32'h0);
        check({tag, "_b_ready"}, {31'b0, b_ready}, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 1'b1;  a_addr = 4'h1;  a_data = 32'h5;
        b_valid = 1'b1;  b_addr_lo = 4'h2;  b_addr_hi = 4'h3;
        b_data_lo = 32'h6;  b_data_hi = 32'h7;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        idle_inputs();
        reset = 1'b0;

        // A-only single write, then idle
        step(1'b1, 4'd3, 32'h11, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        idle(2);
        // B dual write
        step(1'b0, 4'h0, 32'h0, 1'b1, 4'd4, 4'd5, 32'hAAAA, 32'hBBBB);
        idle(3);
        // r15 suppression on A and on B hi half
        step(1'b1, 4'hF, 32'h1234, 1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        idle(1);
        step(1'b0, 4'h0, 32'h0, 1'b1, 4'd6, 4'hF, 32'h66, 32'hFF);
        idle(3);
        // address clash
        step(1'b0, 4'h0, 32'h0, 1'b1, 4'd7, 4'd7, 32'h1, 32'h2);
        idle(3);
        // back-to-back A
        for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 8), 32'(i * 3 + 1), 1'b0, 4'h0, 4'h0, 32'h0, 32'h0);
        idle(1);

        // reset asserted while the hi half is still pending
        step(1'b1, 4'd1, 32'h9, 1'b1, 4'd2, 4'd3, 32'hC0, 32'hC1);
        step(1'b0, 4'h0, 32'h0, 1'b1, 4'd2, 4'd3, 32'hC0, 32'hC1);
        a_valid = 1'b1;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_hi");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(3);

        // contention from reset release
        for (int i = 0; i < 10; i++)
            step(1'b1, 4'(i), 32'h100 + 32'(i), 1'b1, 4'd12, 4'd13, 32'h200 + 32'(i), 32'h300 + 32'(i));
        idle(3);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0] lo;
            logic [3:0] hi;
            lo = 4'($urandom_range(0, 15));
            hi = ($urandom_range(0, 5) == 0) ? lo : 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 2) != 0), 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 2) != 0), lo, hi, $urandom, $urandom);
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic idle_inputs();
        a_valid = 1'b0;  a_addr = 4'h0;  a_data = 32'h0;
        b_valid = 1'b0;  b_addr_lo = 4'h0;  b_addr_hi = 4'h0;
        b_data_lo = 32'h0;  b_data_hi = 32'h0;
    endtask

endmodule

`default_nettype wire
